// File: rtl/pixel_dispatch_sched.sv
// Raster-order pixel scheduler: walks an H_RES x V_RES frame and hands each pixel
// to a ray core through a round-robin req/grant arbiter. Define PIX_DISPATCH_PERF_EN to build the stall counter.
module pixel_dispatch_sched #(
  parameter int H_RES     = 320,
  parameter int V_RES     = 240,
  parameter int X_BITS    = 9,
  parameter int Y_BITS    = 8,
  parameter int NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] req,
  output logic [NUM_CORES-1:0] grant,
  output logic [X_BITS-1:0]    pix_x,
  output logic [Y_BITS-1:0]    pix_y,
  output logic                 busy,
  output logic                 frame_done,
  output logic [31:0]          stall_cycles
);

  localparam int CW = $clog2(NUM_CORES);
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(H_RES - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_RES - 1);
  localparam logic [CW:0]       NC     = (CW + 1)'(NUM_CORES);
  localparam logic [CW-1:0]     RR_MAX = CW'(NUM_CORES - 1);

  typedef enum logic {IDLE, DISPATCH} state_t;

  state_t        state_reg, state_next;
  logic [X_BITS-1:0] pix_x_reg, pix_x_next;
  logic [Y_BITS-1:0] pix_y_reg, pix_y_next;
  logic [CW-1:0] rr_ptr_reg, rr_ptr_next;
  logic          frame_done_reg, frame_done_next;

  logic          active;
  logic          found;
  logic [CW-1:0] win_idx;
  logic          xfer;
  logic          last_pix;
  logic          launch;

  assign active   = (state_reg == DISPATCH) && !abort;
  assign xfer     = active && found;
  assign last_pix = (pix_x_reg == X_LAST) && (pix_y_reg == Y_LAST);
  assign launch   = (state_reg == IDLE) && start && !abort;

  // Search starts at rr_ptr and wraps by subtraction so NUM_CORES need not be a power of two.
  always_comb begin
    logic [CW:0] cand;
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = {1'b0, rr_ptr_reg} + (CW + 1)'(k);
      if (cand >= NC) cand = cand - NC;
      if (!found && req[cand[CW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[CW-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_grant
      assign grant[gi] = active && found && (win_idx == CW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pix_x_reg      <= '0;
      pix_y_reg      <= '0;
      rr_ptr_reg     <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pix_x_reg      <= pix_x_next;
      pix_y_reg      <= pix_y_next;
      rr_ptr_reg     <= rr_ptr_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pix_x_next      = pix_x_reg;
    pix_y_next      = pix_y_reg;
    rr_ptr_next     = rr_ptr_reg;
    frame_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          state_next = DISPATCH;
          pix_x_next = '0;
          pix_y_next = '0;
        end
      end
      DISPATCH: begin
        if (abort) begin
          state_next = IDLE;
        end else if (xfer) begin
          rr_ptr_next = (win_idx == RR_MAX) ? '0 : win_idx + CW'(1);
          // The final pixel leaves the counters parked on (H_RES-1, V_RES-1).
          if (last_pix) begin
            state_next      = IDLE;
            frame_done_next = 1'b1;
          end else if (pix_x_reg == X_LAST) begin
            pix_x_next = '0;
            pix_y_next = pix_y_reg + Y_BITS'(1);
          end else begin
            pix_x_next = pix_x_reg + X_BITS'(1);
          end
        end
      end
    endcase
  end

  assign pix_x      = pix_x_reg;
  assign pix_y      = pix_y_reg;
  assign busy       = (state_reg == DISPATCH);
  assign frame_done = frame_done_reg;

`ifdef PIX_DISPATCH_PERF_EN
  logic [31:0] stall_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_reg <= '0;
    end else if (launch) begin
      stall_reg <= '0;
    end else if ((state_reg == DISPATCH) && !xfer && (stall_reg != 32'hFFFF_FFFF)) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_reg;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pixel_dispatch_sched.sv
// Bench for pixel_dispatch_sched on a 4x2 frame with two cores; compares every
// cycle against a frame-level model (linear pixel index, rotating priority pointer).
module tb_pixel_dispatch_sched;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int N  = 2;
  localparam int XB = 2;
  localparam int YB = 1;
  localparam int VW = N + XB + YB + 2 + 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  grant;
  logic [XB-1:0] pix_x;
  logic [YB-1:0] pix_y;
  logic          busy;
  logic          frame_done;
  logic [31:0]   stall_cycles;

  int checks = 0;
  int failures = 0;

  // frame model
  bit     m_busy;
  bit     m_done;
  int     m_p;
  int     m_rr;
  longint m_stall;

  logic [VW-1:0] exp_vec, obs_vec;

  pixel_dispatch_sched #(
    .H_RES(H), .V_RES(V), .X_BITS(XB), .Y_BITS(YB), .NUM_CORES(N)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .req(req),
    .grant(grant), .pix_x(pix_x), .pix_y(pix_y), .busy(busy),
    .frame_done(frame_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_p = 0; m_rr = 0; m_stall = 0;
  endtask

  function automatic int model_winner(logic [N-1:0] r, logic a);
    if (!m_busy || a) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Apply inputs, then capture observed and model-expected outputs at the falling edge.
  task automatic drive(input logic s, input logic a, input logic [N-1:0] r);
    int w;
    logic [N-1:0] eg;
    logic [31:0] es;
    start = s; abort = a; req = r;
    @(negedge clk);
    w  = model_winner(r, a);
    eg = (w < 0) ? '0 : (N'(1) << w);
`ifdef PIX_DISPATCH_PERF_EN
    es = m_stall[31:0];
`else
    es = 32'd0;
`endif
    exp_vec = {eg, XB'(m_p % H), YB'(m_p / H), logic'(m_busy), logic'(m_done), es};
    obs_vec = {grant, pix_x, pix_y, busy, frame_done, stall_cycles};
  endtask

  task automatic advance();
    int w;
    w = model_winner(req, abort);
    @(posedge clk);
    m_done = 0;
    if (!m_busy) begin
      if (start && !abort) begin
        m_busy = 1; m_p = 0; m_stall = 0;
      end
    end else begin
      if (w < 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (!abort && w >= 0) begin
        $display("xfer core=%0d pix=(%0d,%0d)", w, m_p % H, m_p / H);
        m_rr = (w + 1) % N;
        if (m_p == H * V - 1) begin
          m_busy = 0; m_done = 1;
        end else begin
          m_p++;
        end
      end else if (abort) begin
        m_busy = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; start = 1; req = 2'b11; abort = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs_vec = {grant, pix_x, pix_y, busy, frame_done, stall_cycles};
      if (obs_vec !== '0) begin
        failures++; $display("FAIL reset cyc=%0d got=%h exp=0", i, obs_vec);
      end
      checks++;
    end
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 2'b11);
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 14; i++) begin
      drive(i == 0, 0, 2'b11);
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL full_frame cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 24; i++) begin
      drive(i == 0, 0, ((i % 2) == 1) ? 2'b10 : 2'b00);
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL gaps cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_abort();
    int n = 0;
    bit a;
    for (int i = 0; i < 20; i++) begin
      a = (i > 0) && (n == 2);
      drive(i == 0, a, 2'b11);
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL abort cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      checks++;
      if (i > 0 && !a) n++;
      advance();
      if (a) n = 99;
    end
    // restart after abort runs a complete frame
    for (int i = 0; i < 12; i++) begin
      drive(i == 0, 0, 2'b11);
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL abort_restart cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_collisions();
    bit a;
    drive(1, 1, 2'b11);
    if (obs_vec !== exp_vec) begin
      failures++; $display("FAIL start_abort_idle got=%h exp=%h", obs_vec, exp_vec);
    end
    checks++;
    advance();
    for (int i = 0; i < 14; i++) begin
      // start is re-asserted inside the frame; abort hits the final transfer
      a = m_busy && (m_p == H * V - 1);
      drive((i == 0) ? 1'b1 : 1'($urandom_range(1)), a, 2'b11);
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL collisions cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      checks++;
      advance();
      if (a) break;
    end
    drive(0, 0, 2'b11);
    if (obs_vec !== exp_vec) begin
      failures++; $display("FAIL abort_last got=%h exp=%h", obs_vec, exp_vec);
    end
    checks++;
    advance();
  endtask

  task automatic test_fairness();
    logic [N-1:0] pat [5];
    pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b01; pat[4] = 2'b11;
    for (int i = 0; i < 5; i++) begin
      drive(i == 0, 0, pat[i]);
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL fairness cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      checks++;
      advance();
    end
    drive(0, 1, 2'b11);
    if (obs_vec !== exp_vec) begin
      failures++; $display("FAIL fairness_abort got=%h exp=%h", obs_vec, exp_vec);
    end
    checks++;
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3) == 0, $urandom_range(19) == 0, N'($urandom));
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 0, 2'b11);
      advance();
    end
    reset = 1; start = 0; abort = 0;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 2'b11);
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL reset_midframe cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      checks++;
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_frame();
    test_gaps();
    test_abort();
    test_collisions();
    test_fairness();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
